// File: rtl/bus_target_regs_if.sv
// Bus-target handshake bundle: address/data strobes from the master,
// acknowledge, read data and status back from the register target.
interface bus_target_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              as;
  logic              rw;
  logic              ds;
  logic [DATA_W-1:0] wdata;
  logic              da;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [15:0]       txn_cnt;

  modport master (
    output addr, as, rw, ds, wdata,
    input  da, rdata, err, busy, txn_cnt
  );

  modport slave (
    input  addr, as, rw, ds, wdata,
    output da, rdata, err, busy, txn_cnt
  );
endinterface

// File: rtl/bus_target_regs.sv
// Asynchronous-strobe register target: as/ds handshake with programmable
// wait states, DEPTH data registers, out-of-range flag and transaction count.
module bus_target_regs #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  bus_target_regs_if.slave   bus
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_M1 = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
  localparam logic [DATA_W-1:0] ZERO_D  = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DSWAIT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              da_q, da_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic              do_access_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] wr_data_s;

  assign in_range_s = ({1'b0, addr_q} < DEPTH_L);
  assign idx_s      = addr_q[IDX_W-1:0];

  // Next-state, access and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    da_d        = da_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    txn_cnt_d   = txn_cnt_q;
    regs_d      = regs_q;
    do_access_s = 1'b0;
    wr_data_s   = wdata_q;

    // A new transaction needs as to have been seen low since the last one
    if (!bus.as) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.as && armed_q) begin
          addr_d  = bus.addr;
          rw_d    = bus.rw;
          armed_d = 1'b0;
          state_d = ST_DSWAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DSWAIT: begin
        if (!bus.as) begin
          state_d = ST_IDLE;
        end else if (bus.ds) begin
          wdata_d   = bus.wdata;
          wr_data_s = bus.wdata;
          if (WAIT_CYC == 0) begin
            state_d     = ST_ACK;
            do_access_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_M1;
          end
        end else begin
          state_d = ST_DSWAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.as || !bus.ds) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d     = ST_ACK;
          do_access_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (!bus.as && !bus.ds) begin
          state_d = ST_IDLE;
          da_d    = 1'b0;
          err_d   = 1'b0;
          rdata_d = ZERO_D;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access_s) begin
      da_d      = 1'b1;
      txn_cnt_d = txn_cnt_q + 16'd1;
      if (!in_range_s) begin
        err_d   = 1'b1;
        rdata_d = ZERO_D;
      end else if (rw_q) begin
        err_d   = 1'b0;
        rdata_d = regs_q[idx_s];
      end else begin
        err_d         = 1'b0;
        rdata_d       = ZERO_D;
        regs_d[idx_s] = wr_data_s;
      end
    end else begin
      txn_cnt_d = txn_cnt_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and register-file update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= {ADDR_W{1'b0}};
      rw_q      <= 1'b0;
      wdata_q   <= ZERO_D;
      da_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= ZERO_D;
      busy_q    <= 1'b0;
      txn_cnt_q <= 16'd0;
      armed_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= ZERO_D;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      da_q      <= da_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      txn_cnt_q <= txn_cnt_d;
      armed_q   <= armed_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.da      = da_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.txn_cnt = txn_cnt_q;

endmodule
